pcie_ts_rx_decoder: RTL

Receive-side parser for PCIe Gen1/Gen2 TS1/TS2 training ordered sets on one lane. It sits downstream of the lane's 8b/10b decoder and symbol aligner and upstream of the LTSSM, mirroring the transmit-side ordered-set pattern generator. It consumes one decoded symbol per cycle and validates the 16-symbol TS structure. It publishes the decoded fields and a count of consecutive identical TS received, which the LTSSM uses for its exit conditions (e.g. 8 consecutive TS1/TS2).

---
 rtl/pcie_phy_pkg.sv | 38 +++
 rtl/pcie_ts_rx_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: shared PHY-layer types and constants for the PCIe lane logic.
//   ts_rx_state_e   : receive-side TS parser states (HUNT, COLLECT)
//   training_ctrl_t : TS symbol 5 training-control bit layout
//   rate_id_e       : TS symbol 4 data-rate identifier encodings
//   train_seq_e     : training sequence kind (TS1 / TS2)
//   COM/PAD/TS1/TS2 symbol codes and the ordered-set length
package pcie_phy_pkg;

   typedef enum logic [0:0] {
      TS_HUNT    = 1'b0,
      TS_COLLECT = 1'b1
   } ts_rx_state_e;

   typedef struct packed {
      logic [3:0] rsvd;
      logic       scrambling_dis;
      logic       loopback;
      logic       disable_link;
      logic       hot_reset;
   } training_ctrl_t;

   typedef enum logic [7:0] {
      RATE_GEN1   = 8'h02,
      RATE_GEN1_2 = 8'h06
   } rate_id_e;

   typedef enum logic [0:0] {
      SEQ_TS1 = 1'b0,
      SEQ_TS2 = 1'b1
   } train_seq_e;

   localparam logic [7:0] COM_SYM = 8'hBC;  // K28.5
   localparam logic [7:0] PAD_SYM = 8'hF7;  // K23.7
   localparam logic [7:0] TS1_ID  = 8'h4A;
   localparam logic [7:0] TS2_ID  = 8'h45;
   localparam int         TS_LEN  = 16;

endpackage

// File: rtl/pcie_ts_rx_decoder.sv
// pcie_ts_rx_decoder: single-lane TS1/TS2 ordered-set receive parser.
// Consumes one decoded symbol per accepted cycle, validates the 16-symbol
// TS layout, publishes the decoded fields and counts consecutive identical TS.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rx_data/datak    decoded symbol and its K flag
//   rx_valid         symbol qualifier. A symbol is consumed on every rising
//                    edge where rx_valid=1; there is no back-pressure. With
//                    rx_valid=0 nothing in the parser moves.
//   ts_valid         one-cycle pulse when a well-formed TS is committed
//   ts_type          0 = TS1, 1 = TS2
//   ts_link_num/pad  symbol 1 and its PAD flag
//   ts_lane_num/pad  symbol 2 and its PAD flag
//   ts_n_fts         symbol 3
//   ts_rate_id       symbol 4
//   ts_train_ctl     symbol 5
//   ts_consec_cnt    saturating count of consecutive identical TS
//   ts_consec_hit    ts_consec_cnt >= CONSEC_TARGET
//   ts_err           one-cycle pulse when a malformed TS is aborted
module pcie_ts_rx_decoder
   import pcie_phy_pkg::*;
#(
   parameter int CONSEC_TARGET = 8,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_datak,
   input  logic             rx_valid,
   output logic             ts_valid,
   output logic             ts_type,
   output logic [7:0]       ts_link_num,
   output logic             ts_link_pad,
   output logic [7:0]       ts_lane_num,
   output logic             ts_lane_pad,
   output logic [7:0]       ts_n_fts,
   output logic [7:0]       ts_rate_id,
   output logic [7:0]       ts_train_ctl,
   output logic [CNT_W-1:0] ts_consec_cnt,
   output logic             ts_consec_hit,
   output logic             ts_err
);

   localparam logic [0:0]       ST_HUNT    = TS_HUNT;
   localparam logic [0:0]       ST_COLLECT = TS_COLLECT;
   localparam logic [3:0]       LAST_IDX   = 4'(TS_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_TGT    = CNT_W'(CONSEC_TARGET);

   // FSM state and symbol position, left visible for checkers
   logic [0:0] state;
   logic [3:0] idx;

   // Fields of the TS currently being collected
   logic [7:0]     cur_link;
   logic           cur_link_pad;
   logic [7:0]     cur_lane;
   logic           cur_lane_pad;
   logic [7:0]     cur_n_fts;
   rate_id_e       cur_rate;
   training_ctrl_t cur_ctl;
   train_seq_e     cur_seq;

   logic       is_com;
   logic       is_pad;
   logic [7:0] id_exp;
   logic       sym_ok;
   logic       same_ts;

   always_comb begin
      is_com = rx_datak && (rx_data == COM_SYM);
      is_pad = rx_datak && (rx_data == PAD_SYM);
      id_exp = (cur_seq == SEQ_TS2) ? TS2_ID : TS1_ID;
      sym_ok = 1'b0;
      case (idx)
         4'd1, 4'd2:       sym_ok = !rx_datak || is_pad;
         4'd3, 4'd4, 4'd5: sym_ok = !rx_datak;
         4'd6:             sym_ok = !rx_datak && ((rx_data == TS1_ID) || (rx_data == TS2_ID));
         default:          sym_ok = !rx_datak && (rx_data == id_exp);
      endcase
   end

   // A zero count means no prior commit is held, so nothing can match it.
   always_comb begin
      same_ts = (ts_consec_cnt != '0)
             && (ts_type == (cur_seq == SEQ_TS2))
             && (ts_link_num == cur_link) && (ts_link_pad == cur_link_pad)
             && (ts_lane_num == cur_lane) && (ts_lane_pad == cur_lane_pad)
             && (ts_n_fts == cur_n_fts)
             && (ts_rate_id == 8'(cur_rate))
             && (ts_train_ctl == 8'(cur_ctl));
   end

   assign ts_consec_hit = (ts_consec_cnt >= CNT_TGT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_HUNT;
         idx           <= 4'd0;
         cur_link      <= 8'd0;
         cur_link_pad  <= 1'b0;
         cur_lane      <= 8'd0;
         cur_lane_pad  <= 1'b0;
         cur_n_fts     <= 8'd0;
         cur_rate      <= rate_id_e'(8'd0);
         cur_ctl       <= training_ctrl_t'(8'd0);
         cur_seq       <= SEQ_TS1;
         ts_valid      <= 1'b0;
         ts_err        <= 1'b0;
         ts_type       <= 1'b0;
         ts_link_num   <= 8'd0;
         ts_link_pad   <= 1'b0;
         ts_lane_num   <= 8'd0;
         ts_lane_pad   <= 1'b0;
         ts_n_fts      <= 8'd0;
         ts_rate_id    <= 8'd0;
         ts_train_ctl  <= 8'd0;
         ts_consec_cnt <= '0;
      end else begin
         ts_valid <= 1'b0;
         ts_err   <= 1'b0;
         if (rx_valid) begin
            if (state == ST_HUNT) begin
               if (is_com) begin
                  state <= ST_COLLECT;
                  idx   <= 4'd1;
               end
            end else if (!sym_ok) begin
               ts_err        <= 1'b1;
               ts_consec_cnt <= '0;
               // A COM in the wrong place starts a fresh set right away.
               if (is_com) begin
                  state <= ST_COLLECT;
                  idx   <= 4'd1;
               end else begin
                  state <= ST_HUNT;
                  idx   <= 4'd0;
               end
            end else begin
               case (idx)
                  4'd1: begin cur_link <= rx_data; cur_link_pad <= rx_datak; end
                  4'd2: begin cur_lane <= rx_data; cur_lane_pad <= rx_datak; end
                  4'd3: cur_n_fts <= rx_data;
                  4'd4: cur_rate  <= rate_id_e'(rx_data);
                  4'd5: cur_ctl   <= training_ctrl_t'(rx_data);
                  4'd6: cur_seq   <= (rx_data == TS2_ID) ? SEQ_TS2 : SEQ_TS1;
                  default: ;
               endcase
               if (idx == LAST_IDX) begin
                  state        <= ST_HUNT;
                  idx          <= 4'd0;
                  ts_valid     <= 1'b1;
                  ts_type      <= (cur_seq == SEQ_TS2);
                  ts_link_num  <= cur_link;
                  ts_link_pad  <= cur_link_pad;
                  ts_lane_num  <= cur_lane;
                  ts_lane_pad  <= cur_lane_pad;
                  ts_n_fts     <= cur_n_fts;
                  ts_rate_id   <= 8'(cur_rate);
                  ts_train_ctl <= 8'(cur_ctl);
                  if (!same_ts)
                     ts_consec_cnt <= CNT_W'(1);
                  else if (ts_consec_cnt != CNT_MAX)
                     ts_consec_cnt <= ts_consec_cnt + CNT_W'(1);
               end else begin
                  idx <= idx + 4'd1;
               end
            end
         end
      end
   end

endmodule
